acc_core: RTL

Parametrised accumulator processor core: program counter, instruction register, decoder, ALU, working register W and carry/zero flags in one block. It replaces the separate counter, decode, ALU and W-register instances with a single sequenced datapath. It fetches from an external synchronous instruction memory and executes one instruction every two enabled cycles. Adds configurable data and PC widths, flags, branches, a gated output port, a stall input and a halt state.

---
 rtl/acc_core_if.sv | 13 +
 rtl/acc_core.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/acc_core_if.sv
// Instruction-memory bus between acc_core and a synchronous ROM.
interface acc_core_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 17
);
  localparam int INST_W = DATA_W + 5;

  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_data;

  modport master (output imem_addr, input  imem_data);
  modport slave  (input  imem_addr, output imem_data);
endinterface

// File: rtl/acc_core.sv
// Accumulator processor core: PC, decoder, ALU, W register and C/Z flags.
// Two enabled cycles per instruction (FETCH, EXEC); HALT state is absorbing.
module acc_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  acc_core_if.master        imem,
  output logic [DATA_W-1:0] w,
  output logic              c,
  output logic              z,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted
);

  localparam int INST_W = DATA_W + 5;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_w;
  logic              r_c;
  logic              r_z;
  logic [DATA_W-1:0] r_out;
  logic              r_out_vld;
  logic              r_halted;

  logic [3:0]        w_op;
  logic              w_d;
  logic [DATA_W-1:0] w_k;
  logic [PC_W-1:0]   w_target;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_res;
  logic              w_c_nxt;
  logic              w_z_nxt;
  logic              w_wr_res;
  logic              w_fire;

  assign w_op   = imem.imem_data[INST_W-1:INST_W-4];
  assign w_d    = imem.imem_data[DATA_W];
  assign w_k    = imem.imem_data[DATA_W-1:0];
  assign w_fire = (r_state == S_EXEC) && en;

  // Branch target: zero-extend or truncate the literal to the PC width
  if (PC_W > DATA_W) begin : g_zext
    assign w_target = {{(PC_W-DATA_W){1'b0}}, w_k};
  end else begin : g_trunc
    assign w_target = w_k[PC_W-1:0];
  end

  assign w_pc_inc = r_pc + PC_W'(1);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state: advance only when enabled, HALT opcode parks the core
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: if (en) w_state_nxt = S_EXEC;
      S_EXEC:  if (en) w_state_nxt = (w_op == 4'hF) ? S_HALT : S_FETCH;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // ALU: result and flag candidates for the opcode in imem_data
  always_comb begin
    w_sum    = '0;
    w_res    = '0;
    w_c_nxt  = r_c;
    w_z_nxt  = r_z;
    w_wr_res = 1'b0;
    case (w_op)
      4'h1: begin
        w_sum    = {1'b0, r_w} + {1'b0, w_k};
        w_res    = w_sum[DATA_W-1:0];
        w_c_nxt  = w_sum[DATA_W];
        w_wr_res = 1'b1;
      end
      4'h2: begin
        w_res    = r_w - w_k;
        w_c_nxt  = (r_w >= w_k);
        w_wr_res = 1'b1;
      end
      4'h3: begin w_res = r_w & w_k; w_wr_res = 1'b1; end
      4'h4: begin w_res = r_w | w_k; w_wr_res = 1'b1; end
      4'h5: begin w_res = r_w ^ w_k; w_wr_res = 1'b1; end
      4'h6: begin w_res = w_k;       w_wr_res = 1'b1; end
      4'h7: begin
        w_sum    = {1'b0, r_w} + (DATA_W+1)'(1);
        w_res    = w_sum[DATA_W-1:0];
        w_c_nxt  = w_sum[DATA_W];
        w_wr_res = 1'b1;
      end
      4'h8: begin
        w_res    = r_w - DATA_W'(1);
        w_c_nxt  = (r_w != '0);
        w_wr_res = 1'b1;
      end
      4'h9: begin
        w_res    = {r_w[DATA_W-2:0], r_c};
        w_c_nxt  = r_w[DATA_W-1];
        w_wr_res = 1'b1;
      end
      4'hA: begin
        w_res    = {r_c, r_w[DATA_W-1:1]};
        w_c_nxt  = r_w[0];
        w_wr_res = 1'b1;
      end
      default: ;
    endcase
    if (w_wr_res) w_z_nxt = (w_res == '0);
  end

  // Next PC: sequential, branch, or held on HALT
  always_comb begin
    w_pc_nxt = w_pc_inc;
    case (w_op)
      4'hB: w_pc_nxt = w_target;
      4'hC: w_pc_nxt = r_z ? w_target : w_pc_inc;
      4'hD: w_pc_nxt = r_c ? w_target : w_pc_inc;
      4'hF: w_pc_nxt = r_pc;
      default: ;
    endcase
  end

  // Architectural state commit at the end of an enabled EXEC cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= '0;
      r_w       <= '0;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_out_vld <= 1'b0;
      if (w_fire) begin
        r_pc <= w_pc_nxt;
        if (w_op == 4'hE) begin
          r_w <= '0;
          r_c <= 1'b0;
          r_z <= 1'b1;
        end else if (w_wr_res) begin
          r_c <= w_c_nxt;
          r_z <= w_z_nxt;
          if (w_d) begin
            r_out     <= w_res;
            r_out_vld <= 1'b1;
          end else begin
            r_w <= w_res;
          end
        end
        if (w_op == 4'hF) r_halted <= 1'b1;
      end
    end
  end

  assign imem.imem_addr = r_pc;
  assign w              = r_w;
  assign c              = r_c;
  assign z              = r_z;
  assign out_data       = r_out;
  assign out_valid      = r_out_vld;
  assign halted         = r_halted;

endmodule
